// File: rtl/pe_array_drain.sv
// Result drain for the PE array: snapshots ROWS x COLS results and streams them row-major, LANES values per beat.
// Latency: beat 0 is presented the cycle after the capture handshake, then one beat per cycle while out_ready is high.
// Backpressure: out_ready low freezes the beat and holds cap_ready low; a capture is accepted only when idle or on the last-beat handshake.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-high reset
//   cap_valid / cap_ready    capture handshake; array_in is latched into the shadow register on it
//   array_in                 packed array result, element (r,c) at [(r*COLS+c)*DW +: DW]
//   out_valid / out_ready    output beat handshake
//   out_data                 lane k = element (out_row, out_col_base+k)
//   out_row, out_col_base    position of the current beat in the array
//   out_last                 current beat is the final beat of the frame
//   frames_done              count of fully drained frames, wraps modulo 256
module pe_array_drain #(
  parameter int ROWS  = 2,
  parameter int COLS  = 16,
  parameter int DW    = 16,
  parameter int LANES = 4   // COLS must be a multiple of LANES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cap_valid,
  output logic                      cap_ready,
  input  logic [ROWS*COLS*DW-1:0]   array_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DW-1:0]       out_data,
  output logic [$clog2(ROWS)-1:0]   out_row,
  output logic [$clog2(COLS)-1:0]   out_col_base,
  output logic                      out_last,
  output logic [7:0]                frames_done
);

  localparam int BEATS = ROWS * COLS / LANES;
  localparam int BPR   = COLS / LANES;              // beats per row
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [ROWS*COLS*DW-1:0]   shadow_q;
  logic [BW-1:0]             beat_q;
  logic                      load;       // capture handshake this cycle
  logic                      advance;    // non-last beat accepted
  logic                      frame_end;  // last beat accepted
  logic                      at_last;
  int                        beat_i;

  assign at_last = (beat_q == LAST_BEAT);

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    cap_ready = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        cap_ready = 1'b1;
        if (cap_valid) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = at_last;
        if (out_ready) begin
          if (at_last) begin
            // The shadow is free once its final beat leaves, so a waiting
            // frame is taken in the same cycle and streaming continues gaplessly.
            frame_end = 1'b1;
            cap_ready = 1'b1;
            if (cap_valid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row-major ordering means beat b is simply the b-th LANES*DW slice of the shadow.
  always_comb begin
    beat_i       = int'(beat_q);
    out_row      = RW'(beat_i / BPR);
    out_col_base = CW'((beat_i % BPR) * LANES);
    out_data     = shadow_q[beat_i*LANES*DW +: LANES*DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      beat_q      <= '0;
      frames_done <= 8'd0;
    end else begin
      state_q <= state_d;
      if (load) begin
        shadow_q <= array_in;
        beat_q   <= '0;
      end else if (advance) begin
        beat_q <= beat_q + 1'b1;
      end else if (frame_end) begin
        beat_q <= '0;
      end
      if (frame_end) begin
        frames_done <= frames_done + 8'd1;
      end
    end
  end

endmodule

// File: doc/pe_array_drain.md
# pe_array_drain

Result drain for the 2×16 PE array. It snapshots the full array result (ROWS×COLS values of DW bits) on a capture strobe into a shadow register. It then streams the values out row-major over a valid/ready interface, LANES values per beat. This frees the array to start its next accumulation while the previous result is still being read out.

## Interface

Parameters:
- ROWS, 2, PE rows (weight dimension)
- COLS, 16, PE columns (input-row dimension)
- DW, 16, bits per result value (7 integer + 9 fraction, passed through untouched)
- LANES, 4, values per output beat; COLS must be a multiple of LANES

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- cap_valid  in  1  array result is final and may be captured
- cap_ready  out  1  drain can accept a capture this cycle
- array_in  in  ROWS*COLS*DW  packed result; element (r,c) at bits [(r*COLS+c)*DW +: DW]
- out_valid  out  1  out_data holds a valid beat
- out_ready  in  1  downstream accepts beat
- out_data  out  LANES*DW  lane k = element (out_row, out_col_base+k) at [k*DW +: DW]
- out_row  out  $clog2(ROWS)  row index of current beat
- out_col_base  out  $clog2(COLS)  column of lane 0
- out_last  out  1  current beat is final beat of frame
- frames_done  out  8  count of fully drained frames, wraps 255→0

## Operation

- BEATS = ROWS*COLS/LANES (default 8); beat b covers row b/(COLS/LANES), columns (b%(COLS/LANES))*LANES + 0..LANES-1.
- States: IDLE and SEND.
- IDLE: out_valid=0, cap_ready=1. When cap_valid=1: latch array_in into shadow, clear beat counter, go to SEND.
- SEND: out_valid=1. out_data, out_row, out_col_base and out_last are decoded from the shadow register and the beat counter.
- On out_valid&&out_ready in SEND: if not last, beat counter +1; if last, frames_done +1 and the FSM ends the frame.
- Frame end, back-to-back case: cap_ready = (state==IDLE) || (out_valid && out_ready && out_last). If cap_valid is also high in that cycle, the new frame is latched, the counter is cleared and the FSM stays in SEND. Otherwise the FSM goes to IDLE.
- Shadow register changes only on a capture handshake (cap_valid&&cap_ready). array_in is ignored at all other times.
- Upstream must hold cap_valid until cap_ready. The drain never drops a capture.
- No arithmetic on data: values are passed bit-exact.

## Timing

- Reset (async, on rst rise):
  - outputs: out_valid=0, out_last=0, out_data=0 (shadow cleared), out_row=0, out_col_base=0, frames_done=0
  - internal: state=IDLE, beat counter=0
  - cap_ready=1 while rst is high and after release
- Capture in cycle N produces out_valid=1 with beat 0 in cycle N+1.
- With out_ready held high: one beat per cycle; a frame takes BEATS cycles, beats N+1..N+BEATS.
- Back-to-back captures leave zero idle cycles between frames: beat 0 of frame k+1 follows the last beat of frame k on the next cycle.
- out_valid, once high, stays high. out_data, out_row, out_col_base and out_last stay stable until the handshake.
- out_ready low stalls the counter indefinitely. cap_ready stays 0 during a stall.
- frames_done increments in the cycle after the last-beat handshake.
- Reset mid-frame: out_valid drops immediately (asynchronously), the frame is aborted and frames_done is not incremented. The next capture starts at beat 0.

## Test plan

- **Single frame:** fill element (r,c)=16'h0100*r+c, pulse cap_valid, hold out_ready=1 → 8 beats.
  - beat0 = 64'h0003_0002_0001_0000, row0, col_base0
  - beat4 = 64'h0103_0102_0101_0100, row1, col_base0
  - beat7 = 64'h010F_010E_010D_010C, out_last=1
  - frames_done=1
- **Backpressure:** same frame, out_ready toggled 1,0,0,1,… → out_data and indices frozen while out_ready=0. All 8 beats arrive in order, none duplicated; cap_ready=0 throughout.
- **Back-to-back:** second frame (all 16'hBEEF) presented with cap_valid held during the last beat of frame 1 → captured on the last-beat handshake cycle. Next cycle: beat0 = 64'hBEEF_BEEF_BEEF_BEEF; no out_valid gap; frames_done=2 at the end.
- **Snapshot isolation:** change array_in every cycle during SEND → output data equals the captured frame only.
- **Reset mid-frame:** assert rst after beat 3 is accepted → out_valid=0 and frames_done=0 immediately. New capture after release restarts at beat0 with row0, col_base0.
- **Counter wrap:** drain 256 frames → frames_done reads 255 then 0.
